// File: rtl/athena_hiscore_ctrl_pkg.sv
// Shared types and constants for the hiscore slot-2 bridge sequencer:
// FSM state encoding, bridge address window and CPU work-RAM base.
package athena_hiscore_ctrl_pkg;

   localparam int unsigned HISCORE_SLOT_ID  = 2;
   localparam logic [31:0] HISCORE_START    = 32'h1000_FE50;
   localparam logic [31:0] HISCORE_END      = 32'h1000_FEC1;
   localparam logic [15:0] HISCORE_CPU_BASE = 16'hFE50;
   localparam logic [7:0]  HISCORE_LAST_OFF = 8'(HISCORE_END - HISCORE_START);

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SLOT,
      ACCESS,
      CAPTURE,
      DONE
   } hiscore_state_e;

   function automatic logic hiscore_in_range(input logic [31:0] addr);
      return (addr >= HISCORE_START) && (addr <= HISCORE_END);
   endfunction

endpackage

// File: rtl/athena_hiscore_ctrl_if.sv
// Bridge-side request/ack bus of the hiscore sequencer.
// master = core bridge decoder, slave = athena_hiscore_ctrl.
interface athena_hiscore_ctrl_if;
   logic        bridge_req;
   logic        bridge_wr;
   logic [31:0] bridge_addr;
   logic [31:0] bridge_wdata;
   logic [31:0] bridge_rdata;
   logic        bridge_ack;

   modport master (
      output bridge_req, bridge_wr, bridge_addr, bridge_wdata,
      input  bridge_rdata, bridge_ack
   );

   modport slave (
      input  bridge_req, bridge_wr, bridge_addr, bridge_wdata,
      output bridge_rdata, bridge_ack
   );
endinterface

// File: rtl/athena_hiscore_byte_sel.sv
// Byte lane helper: picks the big-endian write byte for idx, inserts a read
// byte into the assembled word, forms the RAM address and flags the last byte.
module athena_hiscore_byte_sel
   import athena_hiscore_ctrl_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  idx_i,
   input  logic [7:0]  off_i,
   input  logic [7:0]  rbyte_i,
   input  logic [31:0] acc_i,
   output logic [7:0]  wbyte_o,
   output logic [31:0] acc_o,
   output logic [15:0] ram_addr_o,
   output logic        last_o
);
   logic [7:0] byte_off;

   assign byte_off   = off_i + {6'd0, idx_i};
   assign ram_addr_o = HISCORE_CPU_BASE + {8'd0, byte_off};
   // The word ends after lane 3 or at the final byte of the slot window.
   assign last_o     = (idx_i == 2'd3) || (byte_off >= HISCORE_LAST_OFF);

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      wbyte_o = word_i[31:24];
      acc_o   = acc_i;
      case (idx_i)
         2'd0: begin wbyte_o = word_i[31:24]; acc_o[31:24] = rbyte_i; end
         2'd1: begin wbyte_o = word_i[23:16]; acc_o[23:16] = rbyte_i; end
         2'd2: begin wbyte_o = word_i[15:8];  acc_o[15:8]  = rbyte_i; end
         default: begin wbyte_o = word_i[7:0]; acc_o[7:0] = rbyte_i; end
      endcase
   end

endmodule

// File: rtl/athena_hiscore_ctrl.sv
// Hiscore slot-2 bridge sequencer: splits bridge words into byte accesses on the
// shared work-RAM port, using idle CPU cycles. Optional: ATHENA_HISCORE_CPU_STALL_EN.
module athena_hiscore_ctrl
   import athena_hiscore_ctrl_pkg::*;
#(
   parameter int unsigned STALL_TIMEOUT = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   athena_hiscore_ctrl_if.slave        bridge,
   input  logic                        cpu_cs,
   input  logic                        cpu_wr,
   input  logic [15:0]                 cpu_addr,
   input  logic [7:0]                  cpu_wdata,
   output logic                        cpu_wait,
   output logic [15:0]                 ram_addr,
   output logic                        ram_we,
   output logic [7:0]                  ram_wdata,
   input  logic [7:0]                  ram_rdata,
   output logic                        busy
);
   localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);

   hiscore_state_e state_q, state_d;
   logic           wr_q, wr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    acc_q, acc_d;
   logic [31:0]    rdata_q, rdata_d;
   logic [7:0]     off_q, off_d;
   logic [1:0]     idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic           wait_q, wait_d;

   logic [31:0]    acc_ins;
   logic [7:0]     wbyte;
   logic [15:0]    br_addr;
   logic           last;
   logic           grant_bridge;
   logic           stall_hit;

   athena_hiscore_byte_sel u_byte_sel (
      .word_i     (wdata_q),
      .idx_i      (idx_q),
      .off_i      (off_q),
      .rbyte_i    (ram_rdata),
      .acc_i      (acc_q),
      .wbyte_o    (wbyte),
      .acc_o      (acc_ins),
      .ram_addr_o (br_addr),
      .last_o     (last)
   );

`ifdef ATHENA_HISCORE_CPU_STALL_EN
   assign stall_hit = (cnt_q == CNT_W'(STALL_TIMEOUT - 1));
   assign cpu_wait  = wait_q;
`else
   assign stall_hit = 1'b0;
   assign cpu_wait  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      acc_d   = acc_q;
      rdata_d = rdata_q;
      off_d   = off_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;

      case (state_q)
         IDLE: begin
            if (bridge.bridge_req && !bridge.bridge_ack) state_d = LATCH;
         end
         LATCH: begin
            wr_d    = bridge.bridge_wr;
            wdata_d = bridge.bridge_wdata;
            off_d   = 8'(bridge.bridge_addr - HISCORE_START);
            idx_d   = 2'd0;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = hiscore_in_range(bridge.bridge_addr) ? SLOT : DONE;
         end
         SLOT: begin
            // The CPU keeps the port whenever it selects RAM, unless the stall
            // timeout forces one bridge byte through with cpu_wait raised.
            if (!cpu_cs) begin
               state_d = ACCESS;
            end else if (stall_hit) begin
               state_d = ACCESS;
               wait_d  = 1'b1;
            end else if (cnt_q != CNT_W'(STALL_TIMEOUT)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACCESS: begin
            wait_d = 1'b0;
            cnt_d  = '0;
            if (!wr_q)     state_d = CAPTURE;
            else if (last) state_d = DONE;
            else begin
               idx_d   = idx_q + 2'd1;
               state_d = SLOT;
            end
         end
         CAPTURE: begin
            acc_d = acc_ins;
            if (last) state_d = DONE;
            else begin
               idx_d   = idx_q + 2'd1;
               state_d = SLOT;
            end
         end
         default: state_d = IDLE;
      endcase

      // The returned word changes only on entry to DONE and holds until the next ack.
      if (state_d == DONE && state_q != DONE) rdata_d = acc_d;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         acc_q   <= '0;
         rdata_q <= '0;
         off_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         wait_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         acc_q   <= acc_d;
         rdata_q <= rdata_d;
         off_q   <= off_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
      end
   end

   assign grant_bridge        = (state_q == ACCESS);
   assign ram_addr            = grant_bridge ? br_addr : cpu_addr;
   assign ram_we              = grant_bridge ? wr_q    : (cpu_cs & cpu_wr);
   assign ram_wdata           = grant_bridge ? wbyte   : cpu_wdata;
   assign bridge.bridge_ack   = (state_q == DONE);
   assign bridge.bridge_rdata = rdata_q;
   assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_athena_hiscore_ctrl.sv
// Directed bench for athena_hiscore_ctrl: stimulus pushes expected bridge
// responses into a scoreboard queue; a negedge monitor pops and compares on ack.
module tb_athena_hiscore_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_cs, cpu_wr;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_wait;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        busy;

   always #5 clk = ~clk;

   athena_hiscore_ctrl_if bridge ();

   athena_hiscore_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bridge    (bridge),
      .cpu_cs    (cpu_cs),
      .cpu_wr    (cpu_wr),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_wait  (cpu_wait),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .busy      (busy)
   );

   // Work RAM model: synchronous write, registered read of the pre-write contents.
   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we === 1'b1) mem[ram_addr] = ram_wdata;
   end

   int vectors     = 0;
   int miscompares = 0;
   int we_cnt      = 0;
   int wait_cnt    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        chk;
      logic [31:0] rdata;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   // Monitor: every ack consumes one scoreboard entry; read entries compare rdata.
   always @(negedge clk) begin
      if (ram_we === 1'b1)   we_cnt++;
      if (cpu_wait === 1'b1) wait_cnt++;
      if (bridge.bridge_ack === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) check(mon_e.name, bridge.bridge_rdata, mon_e.rdata);
         end
      end
   end

   task automatic push_exp(input logic wr, input logic [31:0] rdata, input string name);
      exp_t e;
      e.chk   = !wr;
      e.rdata = rdata;
      e.name  = name;
      sb_q.push_back(e);
   endtask

   // Called at a negedge with bridge_req already high; lat counts the request cycle as 1.
   task automatic wait_ack(input string name, input int budget, output int lat);
      lat = 1;
      while (1) begin
         @(negedge clk);
         lat++;
         if (bridge.bridge_ack === 1'b1) break;
         if (lat >= budget) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
            break;
         end
      end
      bridge.bridge_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input string name, input int budget,
                       output int lat);
      push_exp(wr, exp_rdata, name);
      bridge.bridge_wr    = wr;
      bridge.bridge_addr  = addr;
      bridge.bridge_wdata = wdata;
      bridge.bridge_req   = 1'b1;
      wait_ack(name, budget, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  lat;
      int  w0;
      logic acked;
      logic cpu_kept;

      bridge.bridge_req   = 1'b0;
      bridge.bridge_wr    = 1'b0;
      bridge.bridge_addr  = '0;
      bridge.bridge_wdata = '0;
      cpu_cs    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'hFEC2] = 8'h77;

      repeat (3) @(negedge clk);
      check("reset_ack",   32'(bridge.bridge_ack), 32'd0);
      check("reset_rdata", bridge.bridge_rdata,    32'd0);
      check("reset_wait",  32'(cpu_wait),          32'd0);
      check("reset_busy",  32'(busy),              32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // CPU owns the port while the bridge is idle.
      cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 8'h99;
      #1;
      check("mux_cpu_addr",  32'(ram_addr),  32'h0042);
      check("mux_cpu_we",    32'(ram_we),    32'd1);
      check("mux_cpu_wdata", 32'(ram_wdata), 32'h99);
      cpu_wr = 1'b0;
      #1;
      check("mux_cpu_rd_we", 32'(ram_we),    32'd0);
      cpu_cs = 1'b0;
      @(negedge clk);

      // 1: full word write, CPU idle.
      xfer(1'b1, 32'h1000_FE50, 32'hA1B2_C3D4, 32'h0, "t1_wr", 40, lat);
      check("t1_lat_le_11", 32'(lat <= 11), 32'd1);
      check("t1_fe50", 32'(mem[16'hFE50]), 32'hA1);
      check("t1_fe51", 32'(mem[16'hFE51]), 32'hB2);
      check("t1_fe52", 32'(mem[16'hFE52]), 32'hC3);
      check("t1_fe53", 32'(mem[16'hFE53]), 32'hD4);

      // 2: read it back.
      xfer(1'b0, 32'h1000_FE50, 32'h0, 32'hA1B2_C3D4, "t2_rd", 40, lat);
      check("t2_lat_le_15", 32'(lat <= 15), 32'd1);

      // 3: partial last word.
      xfer(1'b1, 32'h1000_FEC0, 32'h1122_3344, 32'h0, "t3_wr", 40, lat);
      check("t3_lat_le_7", 32'(lat <= 7), 32'd1);
      check("t3_fec0", 32'(mem[16'hFEC0]), 32'h11);
      check("t3_fec1", 32'(mem[16'hFEC1]), 32'h22);
      check("t3_fec2_untouched", 32'(mem[16'hFEC2]), 32'h77);
      xfer(1'b0, 32'h1000_FEC0, 32'h0, 32'h1122_0000, "t3_rd", 40, lat);
      check("t3_rd_lat_le_9", 32'(lat <= 9), 32'd1);

      // 4: out-of-range write and read.
      w0 = we_cnt;
      xfer(1'b1, 32'h1000_FF00, 32'hDEAD_BEEF, 32'h0, "t4_wr", 20, lat);
      check("t4_wr_lat", 32'(lat), 32'd3);
      check("t4_no_we", 32'(we_cnt - w0), 32'd0);
      xfer(1'b0, 32'h1000_0000, 32'h0, 32'h0, "t4_rd", 20, lat);
      check("t4_rd_lat", 32'(lat), 32'd3);

      // 5: CPU holds cpu_cs high throughout.
      cpu_cs = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h1234;
      w0 = wait_cnt;
`ifdef ATHENA_HISCORE_CPU_STALL_EN
      xfer(1'b1, 32'h1000_FE54, 32'hCAFE_F00D, 32'h0, "t5_wr", 120, lat);
      check("t5_wait_pulses", 32'(wait_cnt - w0), 32'd4);
      check("t5_lat_ge_stall", 32'(lat > 4 * 16), 32'd1);
      cpu_cs = 1'b0;
`else
      push_exp(1'b1, 32'h0, "t5_wr");
      bridge.bridge_wr    = 1'b1;
      bridge.bridge_addr  = 32'h1000_FE54;
      bridge.bridge_wdata = 32'hCAFE_F00D;
      bridge.bridge_req   = 1'b1;
      acked    = 1'b0;
      cpu_kept = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bridge.bridge_ack === 1'b1) acked = 1'b1;
         if (ram_addr !== 16'h1234) cpu_kept = 1'b0;
      end
      check("t5_no_ack_while_cs", 32'(acked),    32'd0);
      check("t5_cpu_keeps_port",  32'(cpu_kept), 32'd1);
      check("t5_busy_waiting",    32'(busy),     32'd1);
      cpu_cs = 1'b0;
      wait_ack("t5_wr", 20, lat);
      check("t5_no_wait", 32'(wait_cnt - w0), 32'd0);
`endif
      check("t5_fe54", 32'(mem[16'hFE54]), 32'hCA);
      check("t5_fe55", 32'(mem[16'hFE55]), 32'hFE);
      check("t5_fe56", 32'(mem[16'hFE56]), 32'hF0);
      check("t5_fe57", 32'(mem[16'hFE57]), 32'h0D);
      xfer(1'b0, 32'h1000_FE54, 32'h0, 32'hCAFE_F00D, "t5_rd", 40, lat);

      // 6: reset after the second byte of a write (written at the 6th edge).
      bridge.bridge_wr    = 1'b1;
      bridge.bridge_addr  = 32'h1000_FE50;
      bridge.bridge_wdata = 32'h0F1E_2D3C;
      bridge.bridge_req   = 1'b1;
      repeat (6) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t6_rst_ack",   32'(bridge.bridge_ack), 32'd0);
      check("t6_rst_rdata", bridge.bridge_rdata,    32'd0);
      check("t6_rst_busy",  32'(busy),              32'd0);
      check("t6_rst_wait",  32'(cpu_wait),          32'd0);
      check("t6_rst_we",    32'(ram_we),            32'd0);
      bridge.bridge_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("t6_fe50_new", 32'(mem[16'hFE50]), 32'h0F);
      check("t6_fe51_new", 32'(mem[16'hFE51]), 32'h1E);
      check("t6_fe52_old", 32'(mem[16'hFE52]), 32'hC3);
      check("t6_fe53_old", 32'(mem[16'hFE53]), 32'hD4);
      xfer(1'b0, 32'h1000_FE50, 32'h0, 32'h0F1E_C3D4, "t6_rd_after_rst", 40, lat);

      repeat (2) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
